uart_cmd_parser: RTL

//  Frames the UART receiver byte stream into ALU commands. Hunts for SOF, collects

---
 rtl/uart_cmd_parser.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - frames UART receiver bytes into ALU commands with valid/ready hand-off
//
// Frame on the wire: SOF, number1, number2, sel, EOF. A complete, well-formed frame
// is held on cmd_* with cmd_valid until the consumer takes it (cmd_valid && cmd_ready).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   rx_data      byte from receiver, qualified by rx_done
//   rx_done      one-cycle byte strobe
//   sample_tick  baud tick, only used for the inter-byte timeout
//   cmd_number1  operand 1 (stable while cmd_valid)
//   cmd_number2  operand 2 (stable while cmd_valid)
//   cmd_sel      operation select, 1..4
//   cmd_valid    command available
//   cmd_ready    consumer accepts
//   err_frame    one-cycle pulse: bad length, bad sel, SOF resync or timeout
//   err_overrun  one-cycle pulse: byte dropped while a command is held
//   busy         frame in progress or command held
//   frames_ok    accepted-command count, wrapping
//   frames_err   err_frame count, saturating
module uart_cmd_parser #(
  parameter int               DBITS    = 8,
  parameter logic [DBITS-1:0] SOF_BYTE = 8'h0C,
  parameter logic [DBITS-1:0] EOF_BYTE = 8'h0A,
  parameter int               TO_TICKS = 2560,
  parameter int               TO_BITS  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] rx_data,
  input  logic             rx_done,
  input  logic             sample_tick,
  output logic [DBITS-1:0] cmd_number1,
  output logic [DBITS-1:0] cmd_number2,
  output logic [2:0]       cmd_sel,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             err_frame,
  output logic             err_overrun,
  output logic             busy,
  output logic [7:0]       frames_ok,
  output logic [7:0]       frames_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         cnt;
  logic [TO_BITS-1:0] to_cnt;

  logic is_sof;
  logic is_eof;
  logic sel_ok;
  logic timeout_hit;
  logic frame_err_evt;
  logic xfer;

  // Event decode shared by the error pulse, the error counter and the FSM so all
  // three agree on the same cycle.
  always_comb begin
    is_sof        = (rx_data == SOF_BYTE);
    is_eof        = (rx_data == EOF_BYTE);
    sel_ok        = (cmd_sel != 3'd0) && (cmd_sel <= 3'd4);
    // A byte arriving together with the final tick wins, so timeout needs !rx_done.
    timeout_hit   = (state == COLLECT) && !rx_done && sample_tick &&
                    (to_cnt == TO_BITS'(TO_TICKS - 1));
    frame_err_evt = 1'b0;
    if (state == COLLECT) begin
      if (rx_done) begin
        frame_err_evt = is_sof ||
                        (is_eof && !((cnt == 2'd3) && sel_ok)) ||
                        (!is_eof && !is_sof && (cnt == 2'd3));
      end else begin
        frame_err_evt = timeout_hit;
      end
    end
    xfer = cmd_valid && cmd_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      to_cnt      <= '0;
      cmd_number1 <= '0;
      cmd_number2 <= '0;
      cmd_sel     <= 3'd0;
      cmd_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
      busy        <= 1'b0;
      frames_ok   <= 8'd0;
      frames_err  <= 8'd0;
    end else begin
      err_frame   <= frame_err_evt;
      err_overrun <= 1'b0;
      if (frame_err_evt && (frames_err != 8'hFF)) begin
        frames_err <= frames_err + 8'd1;
      end

      case (state)
        IDLE: begin
          if (rx_done && is_sof) begin
            state  <= COLLECT;
            busy   <= 1'b1;
            cnt    <= 2'd0;
            to_cnt <= '0;
          end
        end

        COLLECT: begin
          if (rx_done) begin
            to_cnt <= '0;
            if (is_eof) begin
              if ((cnt == 2'd3) && sel_ok) begin
                state     <= HOLD;
                cmd_valid <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else if (is_sof) begin
              cnt <= 2'd0;
            end else if (cnt == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              // Payload lands directly in the output registers; cmd_valid is low
              // here so the consumer never sees a partial command.
              case (cnt)
                2'd0:    cmd_number1 <= rx_data;
                2'd1:    cmd_number2 <= rx_data;
                default: cmd_sel     <= rx_data[2:0];
              endcase
              cnt <= cnt + 2'd1;
            end
          end else if (timeout_hit) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
          end else if (sample_tick) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (xfer) begin
            cmd_valid <= 1'b0;
            frames_ok <= frames_ok + 8'd1;
            // The transfer cycle behaves like IDLE for an incoming byte.
            if (rx_done && is_sof) begin
              state  <= COLLECT;
              cnt    <= 2'd0;
              to_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (rx_done) begin
            err_overrun <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
